fetch_queue: RTL and testbench

//  Decoupling FIFO between the fetch stage and the issue stage (rs_scheduler / new_pc).

---
 rtl/fetch_queue_if.sv | 37 +++
 rtl/fetch_queue.sv | 70 +++++++
 tb/tb_fetch_queue.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-to-issue queue bundle: packet type plus the handshake interface shared by
// fetch (master side) and the queue (slave side).
package fetch_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
  } pipe_in_t;
endpackage

interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_squash;
  pipe_in_t         in_data;
  logic             in_ready;
  logic             out_valid;
  pipe_in_t         out_data;
  logic             out_yumi;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_squash, in_data, out_yumi,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_squash, in_data, out_yumi,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and issue; holds the head packet until issue takes it
// and squashes everything on a mispredict flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,  // synchronous, active-low
  fetch_queue_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  pipe_in_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Status comes only from registered count, so a same-cycle pop never frees a slot.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.in_valid & ~w_full & ~bus.in_squash & ~bus.flush;
  assign w_pop   = bus.out_yumi & ~w_empty & ~bus.flush;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= bus.in_data;
        r_tail        <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = w_empty ? '0 : r_mem[r_head];
  assign bus.count     = r_count;

  a_count_bound : assert property (@(posedge i_clk) disable iff (!i_reset)
    r_count <= CNT_W'(DEPTH));
  a_empty_valid : assert property (@(posedge i_clk) disable iff (!i_reset)
    (r_count == '0) == !bus.out_valid);
  a_full_ready : assert property (@(posedge i_clk) disable iff (!i_reset)
    (r_count == CNT_W'(DEPTH)) == !bus.in_ready);
endmodule

// File: tb/tb_fetch_queue.sv
// Directed vector bench for fetch_queue: table of per-edge stimulus with expected
// post-edge outputs, plus hand-written wrap, full, flush and squash sequences.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_squash;
    logic [31:0] pc;
    logic        yumi;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    int          exp_cnt;
  } vec_t;

  logic clk;
  logic i_reset;
  int   total;
  int   bad;
  int   vid;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pipe_in_t mkdata(input logic [31:0] pc);
    pipe_in_t d;
    d.pc         = pc;
    d.instr      = ~pc;
    d.pred_taken = pc[2];
    return d;
  endfunction

  task automatic chk(input int id, input string nm, input logic [64:0] got,
                     input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL vec%0d %s: got %h want %h", id, nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    i_reset       = ~v.rst;
    bus.flush     = v.flush;
    bus.in_valid  = v.in_valid;
    bus.in_squash = v.in_squash;
    bus.in_data   = mkdata(v.pc);
    bus.out_yumi  = v.yumi;
  endtask

  task automatic check(input vec_t v);
    pipe_in_t exp_d;
    exp_d = v.exp_valid ? mkdata(v.exp_pc) : '0;
    chk(vid, "in_ready", 65'(bus.in_ready), 65'(v.exp_ready));
    chk(vid, "out_valid", 65'(bus.out_valid), 65'(v.exp_valid));
    chk(vid, "count", 65'(bus.count), 65'(v.exp_cnt));
    chk(vid, "out_data", 65'(bus.out_data), 65'(exp_d));
  endtask

  task automatic apply(input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check(v);
    vid++;
  endtask

  vec_t tbl [15];

  initial begin
    vec_t v;
    total = 0;
    bad   = 0;
    vid   = 0;

    //          rst  fl   iv   sq   pc      yumi rdy  vld  exp_pc  cnt
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h00, 1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h04, 1'b0, 1'b1, 1'b1, 32'h00, 2};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h08, 1'b0, 1'b1, 1'b1, 32'h00, 3};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0C, 1'b0, 1'b0, 1'b1, 32'h00, 4};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 1'b1, 32'h00, 4};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h04, 3};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h08, 2};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h0C, 1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 1'b0, 1'b1, 1'b1, 32'h20, 1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h24, 1'b0, 1'b1, 1'b1, 32'h20, 2};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h28, 1'b1, 1'b1, 1'b1, 32'h24, 2};

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i]);
    end

    // Queue holds {0x24,0x28}; 12 push+pop cycles wrap both pointers three times.
    for (int i = 0; i < 12; i++) begin
      v = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h100 + 32'(4 * i), 1'b1, 1'b1, 1'b1,
            (i == 0) ? 32'h28 : 32'h100 + 32'(4 * (i - 1)), 2};
      apply(v);
    end

    // Queue holds {0x128,0x12C}; fill to full.
    apply('{1'b0, 1'b0, 1'b1, 1'b0, 32'h130, 1'b0, 1'b1, 1'b1, 32'h128, 3});
    apply('{1'b0, 1'b0, 1'b1, 1'b0, 32'h134, 1'b0, 1'b0, 1'b1, 32'h128, 4});

    // Full + yumi + in_valid: pop only, and in_ready must not rise before the edge.
    v = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h138, 1'b1, 1'b1, 1'b1, 32'h12C, 3};
    drive(v);
    #1;
    chk(vid, "no_comb_ready", 65'(bus.in_ready), 65'(1'b0));
    @(posedge clk);
    #1;
    check(v);
    vid++;

    // Flush at count=3 with push and pop requested: everything squashed.
    apply('{1'b0, 1'b1, 1'b1, 1'b0, 32'h13C, 1'b1, 1'b1, 1'b0, 32'h000, 0});
    apply('{1'b0, 1'b0, 1'b1, 1'b0, 32'h040, 1'b0, 1'b1, 1'b1, 32'h040, 1});

    // Squashed packet never enters.
    apply('{1'b0, 1'b0, 1'b1, 1'b1, 32'h050, 1'b0, 1'b1, 1'b1, 32'h040, 1});
    apply('{1'b0, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 32'h000, 0});

    // Reset mid-stream beats a same-cycle push; nothing stale afterwards.
    apply('{1'b0, 1'b0, 1'b1, 1'b0, 32'h060, 1'b0, 1'b1, 1'b1, 32'h060, 1});
    apply('{1'b0, 1'b0, 1'b1, 1'b0, 32'h064, 1'b0, 1'b1, 1'b1, 32'h060, 2});
    apply('{1'b1, 1'b0, 1'b1, 1'b0, 32'h068, 1'b1, 1'b1, 1'b0, 32'h000, 0});
    apply('{1'b0, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 32'h000, 0});
    apply('{1'b0, 1'b0, 1'b1, 1'b0, 32'h06C, 1'b0, 1'b1, 1'b1, 32'h06C, 1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
